wallace_tree_mult: RTL and testbench

- Unsigned WIDTH x WIDTH multiplier built as a Wallace tree: partial-product generation, 3:2/2:2 carry-save reduction to two rows, then a final carry-propagate adder.
- Optionally pipelined, with a valid_in/valid_out handshake.
- Used as a datapath arithmetic block that accepts one operand pair per cycle and returns a 2*WIDTH-bit product after a fixed latency.

---
 rtl/wallace_tree_mult.sv | 134 +++++++++++++
 tb/tb_wallace_tree_mult.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wallace_tree_mult.sv
// Unsigned WIDTH x WIDTH Wallace-tree multiplier: partial products, carry-save
// reduction to two rows, final carry-propagate add. Optional 3-stage pipeline.
module wallace_tree_mult #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned PIPELINED = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 valid_in,
  output logic [2*WIDTH-1:0]   product,
  output logic                 valid_out,
  output logic                 done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef logic [PW-1:0] row_t;

  row_t pp_c    [WIDTH];
  row_t tree_in [WIDTH];
  row_t sum_c;
  row_t carry_c;
  row_t fin_a;
  row_t fin_b;
  logic fin_v;

  // Partial-product rows: row i is a shifted left by i when b[i] is set.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
    assign pp_c[gi] = b[gi] ? (PW'(a) << gi) : '0;
  end

  // Carry-save reduction: each level maps groups of three rows onto a sum row
  // and a shifted majority row; leftover rows pass through until two remain.
  always_comb begin : tree_b
    row_t        lvl_rows [WIDTH];
    row_t        nxt_rows [WIDTH];
    row_t        x;
    row_t        y;
    row_t        z;
    int unsigned n;
    int unsigned m;
    lvl_rows = tree_in;
    nxt_rows = '{default: '0};
    x        = '0;
    y        = '0;
    z        = '0;
    n        = WIDTH;
    m        = 0;
    for (int unsigned l = 0; l < WIDTH; l++) begin
      if (n > 2) begin
        nxt_rows = '{default: '0};
        m        = 0;
        for (int unsigned g = 0; g < WIDTH / 3; g++) begin
          if (3 * g + 2 < n) begin
            x = lvl_rows[IW'(3 * g)];
            y = lvl_rows[IW'(3 * g + 1)];
            z = lvl_rows[IW'(3 * g + 2)];
            nxt_rows[IW'(m)]     = x ^ y ^ z;
            nxt_rows[IW'(m + 1)] = ((x & y) | (x & z) | (y & z)) << 1;
            m = m + 2;
          end
        end
        for (int unsigned k = 0; k < WIDTH; k++) begin
          if (k >= 3 * (n / 3) && k < n) begin
            nxt_rows[IW'(m)] = lvl_rows[IW'(k)];
            m = m + 1;
          end
        end
        lvl_rows = nxt_rows;
        n        = m;
      end
    end
    sum_c   = lvl_rows[0];
    carry_c = lvl_rows[1];
  end

  if (PIPELINED != 0) begin : g_pipe
    row_t pp_q [WIDTH];
    row_t sum_q;
    row_t carry_q;
    logic v1_q;
    logic v2_q;

    // Stage 1 holds partial products, stage 2 holds the carry-save pair.
    always_ff @(posedge clk) begin
      if (rst) begin
        pp_q    <= '{default: '0};
        sum_q   <= '0;
        carry_q <= '0;
        v1_q    <= 1'b0;
        v2_q    <= 1'b0;
      end else begin
        v1_q <= valid_in;
        v2_q <= v1_q;
        if (valid_in) pp_q <= pp_c;
        if (v1_q) begin
          sum_q   <= sum_c;
          carry_q <= carry_c;
        end
      end
    end

    always_comb begin
      tree_in = pp_q;
      fin_a   = sum_q;
      fin_b   = carry_q;
      fin_v   = v2_q;
    end
  end else begin : g_comb
    always_comb begin
      tree_in = pp_c;
      fin_a   = sum_c;
      fin_b   = carry_c;
      fin_v   = valid_in;
    end
  end

  // Final adder and output register; product only moves on a valid result.
  always_ff @(posedge clk) begin
    if (rst) begin
      product   <= '0;
      valid_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      valid_out <= fin_v;
      done      <= fin_v;
      if (fin_v) product <= fin_a + fin_b;
    end
  end

endmodule

// File: tb/tb_wallace_tree_mult.sv
// Self-checking bench: a pipelined 16-bit and a combinational 32-bit instance
// driven together and compared every cycle against a cycle-indexed history model.
module tb_wallace_tree_mult;

  localparam int HN = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;
  logic [31:0] p16;
  logic [63:0] p32;
  logic        vo16, d16, vo32, d32;

  int n_chk = 0;
  int n_pass = 0;
  int e = 0;

  bit          hv   [HN];
  bit          hr   [HN];
  logic [31:0] hp16 [HN];
  logic [63:0] hp32 [HN];
  logic [31:0] ep16;
  logic [63:0] ep32;
  bit          ev16, ev32;

  always #5 clk = ~clk;

  wallace_tree_mult #(.WIDTH(16), .PIPELINED(1)) u16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .valid_in(valid_in),
    .product(p16), .valid_out(vo16), .done(d16)
  );

  wallace_tree_mult #(.WIDTH(32), .PIPELINED(0)) u32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .valid_in(valid_in),
    .product(p32), .valid_out(vo32), .done(d32)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @edge %0d: got %h expected %h", tag, e, got, exp);
  endtask

  task automatic drive(input logic v, input logic r, input logic [15:0] x16, input logic [15:0] y16,
                       input logic [31:0] x32, input logic [31:0] y32);
    valid_in = v;
    rst      = r;
    a16      = x16;
    b16      = y16;
    a32      = x32;
    b32      = y32;
  endtask

  // One rising edge: log what was sampled, advance the model, compare outputs.
  task automatic tick();
    @(posedge clk);
    e++;
    if (e >= HN) begin
      $display("FAIL edge_budget: got %0d expected below %0d", e, HN);
      $fatal(1, "history exhausted");
    end
    hr[e]   = rst;
    hv[e]   = valid_in && !rst;
    hp16[e] = 32'(a16) * 32'(b16);
    hp32[e] = 64'(a32) * 64'(b32);

    if (rst) begin
      ev16 = 1'b0;
      ep16 = '0;
    end else if (e >= 2 && hv[e-2] && !hr[e-1]) begin
      ev16 = 1'b1;
      ep16 = hp16[e-2];
    end else begin
      ev16 = 1'b0;
    end

    if (rst) begin
      ev32 = 1'b0;
      ep32 = '0;
    end else begin
      ev32 = hv[e];
      if (hv[e]) ep32 = hp32[e];
    end

    #1;
    check("p16",  64'(p16),  64'(ep16));
    check("vo16", 64'(vo16), 64'(ev16));
    check("d16",  64'(d16),  64'(ev16));
    check("p32",  p32,       ep32);
    check("vo32", 64'(vo32), 64'(ev32));
    check("d32",  64'(d32),  64'(ev32));
  endtask

  // Single pulse with literal expectations; operands are scrambled after capture.
  task automatic directed(input logic [15:0] x16, input logic [15:0] y16, input logic [31:0] l16,
                          input logic [31:0] x32, input logic [31:0] y32, input logic [63:0] l32);
    drive(1'b1, 1'b0, x16, y16, x32, y32);
    tick();
    check("lit32", p32, l32);
    check("lit32_v", 64'(vo32), 64'd1);
    drive(1'b0, 1'b0, 16'($urandom), 16'($urandom), $urandom, $urandom);
    tick();
    check("lat16_early", 64'(vo16), 64'd0);
    tick();
    check("lit16", 64'(p16), 64'(l16));
    check("lit16_v", 64'(vo16), 64'd1);
    tick();
  endtask

  initial begin
    drive(1'b0, 1'b1, '0, '0, '0, '0);
    repeat (5) tick();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (2) tick();

    directed(16'd0,     16'd0,     32'd0,          32'd0,     32'd0,     64'd0);
    directed(16'd0,     16'd123,   32'd0,          32'd0,     32'd123,   64'd0);
    directed(16'd45,    16'd0,     32'd0,          32'd45,    32'd0,     64'd0);
    directed(16'd1,     16'd1,     32'd1,          32'd1,     32'd1,     64'd1);
    directed(16'd65535, 16'd1,     32'd65535,      32'd65535, 32'd1,     64'd65535);
    directed(16'd1,     16'd65535, 32'd65535,      32'd1,     32'd65535, 64'd65535);
    directed(16'hFFFF,  16'hFFFF,  32'hFFFE0001,   32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    directed(16'hAAAA,  16'h5555,  32'h38E31C72,   32'h80000000, 32'h80000000, 64'h4000000000000000);
    directed(16'hFF00,  16'h00FF,  32'h00FE0100,   32'hFF00,  32'hFF,    64'h00FE0100);
    directed(16'h8000,  16'h8000,  32'h40000000,   32'h8000,  32'h8000,  64'h40000000);
    directed(16'd32767, 16'd2,     32'd65534,      32'd32767, 32'd2,     64'd65534);
    directed(16'd2,     16'd4,     32'd8,          32'd64,    32'd128,   64'd8192);
    directed(16'd255,   16'd255,   32'd65025,      32'd1000,  32'd100,   64'd100000);
    directed(16'd47,    16'd53,    32'd2491,       32'd250,   32'd250,   64'd62500);

    // Back-to-back stream, then the same with a one-cycle bubble.
    drive(1'b1, 1'b0, 16'd3,    16'd5,   32'd3,   32'd5);   tick();
    drive(1'b1, 1'b0, 16'd7,    16'd9,   32'd7,   32'd9);   tick();
    drive(1'b1, 1'b0, 16'd100,  16'd200, 32'd100, 32'd200); tick();
    check("stream_15", 64'(p16), 64'd15);
    drive(1'b1, 1'b0, 16'hFFFF, 16'd2,   32'hFFFF, 32'd2);  tick();
    check("stream_63", 64'(p16), 64'd63);
    drive(1'b0, 1'b0, '0, '0, '0, '0);                       tick();
    check("stream_20000", 64'(p16), 64'd20000);
    tick();
    check("stream_131070", 64'(p16), 64'd131070);
    drive(1'b1, 1'b0, 16'd3,   16'd5,   32'd3,   32'd5);    tick();
    drive(1'b0, 1'b0, '0, '0, '0, '0);                       tick();
    drive(1'b1, 1'b0, 16'd100, 16'd200, 32'd100, 32'd200);  tick();
    drive(1'b0, 1'b0, '0, '0, '0, '0);                       tick();
    check("bubble_gap", 64'(vo16), 64'd0);
    repeat (3) tick();

    // Reset one edge after capture, with valid_in also high during reset.
    drive(1'b1, 1'b0, 16'h1234, 16'h10, 32'h1234, 32'h10); tick();
    drive(1'b1, 1'b1, 16'h7777, 16'h3,  32'h7777, 32'h3);  tick();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (4) begin
      tick();
      check("midrst_no_valid", 64'(vo16), 64'd0);
    end

    // Random traffic with sporadic resets and occasional extreme operands.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] x16, y16;
      logic [31:0] x32, y32;
      x16 = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      y16 = 16'($urandom);
      x32 = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFF : $urandom;
      y32 = $urandom;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0), x16, y16, x32, y32);
      tick();
    end
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
